// File: rtl/dino_motion_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dino_motion_pkg
// Brief   : Shared encodings and default constants for the dino motion block.
// Revision: 1.0 - initial release
// ============================================================================
package dino_motion_pkg;

    localparam logic [1:0] c_GS_IDLE = 2'b00;
    localparam logic [1:0] c_GS_PLAY = 2'b01;
    localparam logic [1:0] c_GS_DEAD = 2'b10;

    localparam logic [2:0] c_POSE_STAND  = 3'd0;
    localparam logic [2:0] c_POSE_RUN_A  = 3'd1;
    localparam logic [2:0] c_POSE_RUN_B  = 3'd2;
    localparam logic [2:0] c_POSE_DUCK_A = 3'd3;
    localparam logic [2:0] c_POSE_DUCK_B = 3'd4;
    localparam logic [2:0] c_POSE_AIR    = 3'd5;
    localparam logic [2:0] c_POSE_DEAD   = 3'd6;

    localparam int c_DEF_GROUND_Y = 360;
    localparam int c_DEF_DINO_H   = 47;
    localparam int c_DEF_DUCK_H   = 30;
    localparam int c_DEF_JUMP_V   = 15;

    typedef enum logic [1:0] {
        MS_RUN  = 2'd0,
        MS_AIR  = 2'd1,
        MS_DEAD = 2'd2
    } motion_t;

endpackage
`default_nettype wire

// File: rtl/rise_pulse.sv
`default_nettype none
// ============================================================================
// Module  : rise_pulse
// Brief   : Rising-edge detector with a registered history bit.
// Revision: 1.0 - initial release
// ============================================================================
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= i_level;
    end

    assign o_pulse = i_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/dino_motion.sv
`default_nettype none
// ============================================================================
// Module  : dino_motion
// Brief   : Dino jump/duck physics, pose selection and sprite placement.
// Revision: 1.0 - initial release
// ============================================================================
module dino_motion
    import dino_motion_pkg::*;
#(
    parameter int GROUND_Y = c_DEF_GROUND_Y,
    parameter int DINO_H   = c_DEF_DINO_H,
    parameter int DUCK_H   = c_DEF_DUCK_H,
    parameter int JUMP_V   = c_DEF_JUMP_V
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       anim_tick,
    input  logic       jump,
    input  logic       duck,
    input  logic [1:0] game_state,
    output logic       start_req,
    output logic [9:0] dino_y,
    output logic [5:0] dino_h,
    output logic [2:0] pose,
    output logic       airborne
);

    localparam logic [9:0] c_GROUND = 10'(GROUND_Y);
    localparam logic [5:0] c_STAND  = 6'(DINO_H);
    localparam logic [5:0] c_DUCK   = 6'(DUCK_H);

    motion_t            r_state, w_state_nxt;
    logic [7:0]         r_h, w_h_nxt;
    logic signed [5:0]  r_v, w_v_nxt;
    logic               r_pend, w_pend_nxt;
    logic               r_phase, w_phase_nxt;

    logic               w_edge;
    logic signed [9:0]  w_sum;
    logic signed [9:0]  w_vdec;
    logic               w_start_nxt;
    logic [5:0]         w_dino_h_nxt;
    logic [9:0]         w_dino_y_nxt;
    logic [2:0]         w_pose_nxt;
    logic               w_air_nxt;

    rise_pulse u_jump_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (jump),
        .o_pulse (w_edge)
    );

    assign w_sum  = $signed({2'b00, r_h}) + $signed({{4{r_v[5]}}, r_v});
    assign w_vdec = $signed({{4{r_v[5]}}, r_v}) - (duck ? 10'sd3 : 10'sd1);

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        w_pend_nxt  = r_pend;
        w_phase_nxt = r_phase;
        w_start_nxt = 1'b0;

        case (game_state)
            c_GS_IDLE: begin
                w_state_nxt = MS_RUN;
                w_h_nxt     = 8'd0;
                w_v_nxt     = 6'sd0;
                w_pend_nxt  = 1'b0;
                w_start_nxt = w_edge;
            end
            c_GS_PLAY: begin
                if (r_state != MS_DEAD) begin
                    if (w_edge) w_pend_nxt = 1'b1;
                    // Pending is single-frame: an edge not taken at this tick is lost.
                    if (frame_tick) begin
                        w_pend_nxt = 1'b0;
                        if (r_state == MS_RUN && r_pend) begin
                            w_state_nxt = MS_AIR;
                            w_h_nxt     = 8'(JUMP_V);
                            w_v_nxt     = 6'(JUMP_V - 1);
                        end else if (r_state == MS_AIR) begin
                            if (w_sum <= 10'sd0) begin
                                w_state_nxt = MS_RUN;
                                w_h_nxt     = 8'd0;
                                w_v_nxt     = 6'sd0;
                            end else begin
                                w_h_nxt = (w_sum > 10'sd255) ? 8'd255 : w_sum[7:0];
                                w_v_nxt = (w_vdec < -10'sd31) ? -6'sd31 : w_vdec[5:0];
                            end
                        end
                    end
                    if (anim_tick && r_state == MS_RUN) w_phase_nxt = ~r_phase;
                end
            end
            default: begin
                w_state_nxt = MS_DEAD;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_dino_h_nxt = c_STAND;
        w_pose_nxt   = c_POSE_STAND;
        case (w_state_nxt)
            MS_DEAD: w_pose_nxt = c_POSE_DEAD;
            MS_AIR:  w_pose_nxt = c_POSE_AIR;
            default: begin
                if (game_state == c_GS_PLAY) begin
                    if (duck) begin
                        w_dino_h_nxt = c_DUCK;
                        w_pose_nxt   = w_phase_nxt ? c_POSE_DUCK_B : c_POSE_DUCK_A;
                    end else begin
                        w_pose_nxt   = w_phase_nxt ? c_POSE_RUN_B : c_POSE_RUN_A;
                    end
                end
            end
        endcase
        w_dino_y_nxt = c_GROUND - {4'b0000, w_dino_h_nxt} - {2'b00, w_h_nxt};
        w_air_nxt    = (w_h_nxt != 8'd0) ||
                       (w_state_nxt == MS_AIR && w_v_nxt > 6'sd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MS_RUN;
            r_h       <= 8'd0;
            r_v       <= 6'sd0;
            r_pend    <= 1'b0;
            r_phase   <= 1'b0;
            start_req <= 1'b0;
            dino_h    <= c_STAND;
            dino_y    <= c_GROUND - {4'b0000, c_STAND};
            pose      <= c_POSE_STAND;
            airborne  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            r_pend    <= w_pend_nxt;
            r_phase   <= w_phase_nxt;
            start_req <= w_start_nxt;
            dino_h    <= w_dino_h_nxt;
            dino_y    <= w_dino_y_nxt;
            pose      <= w_pose_nxt;
            airborne  <= w_air_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dino_motion.sv
`default_nettype none
// ============================================================================
// Module  : tb_dino_motion
// Brief   : Directed vector table plus jump/duck/dead/idle/reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dino_motion;

    logic       clk = 1'b0;
    logic       rst, frame_tick, anim_tick, jump, duck;
    logic [1:0] game_state;
    logic       start_req, airborne;
    logic [9:0] dino_y;
    logic [5:0] dino_h;
    logic [2:0] pose;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dino_motion dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .anim_tick  (anim_tick),
        .jump       (jump),
        .duck       (duck),
        .game_state (game_state),
        .start_req  (start_req),
        .dino_y     (dino_y),
        .dino_h     (dino_h),
        .pose       (pose),
        .airborne   (airborne)
    );

    typedef struct {
        logic       ft, at, jp, dk;
        logic [1:0] gs;
        logic [9:0] y;
        logic [5:0] h;
        logic [2:0] ps;
        logic       air;
        logic       sr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_tick = 1'b0; anim_tick = 1'b0;
        jump = 1'b0; duck = 1'b0; game_state = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_jump();
        game_state = 2'b01;
        step();
        jump = 1'b1;
        step();
    endtask

    initial begin
        int exp_h;
        rst = 1'b1; frame_tick = 1'b0; anim_tick = 1'b0;
        jump = 1'b0; duck = 1'b0; game_state = 2'b00;
        step();
        chk("rst_y", dino_y, 313);
        chk("rst_h", dino_h, 47);
        chk("rst_pose", pose, 0);
        chk("rst_air", airborne, 0);
        chk("rst_start", start_req, 0);
        do_reset();

        // Running/ducking leg animation and idle return
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 10'd313, 6'd47, 3'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 10'd313, 6'd47, 3'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 10'd313, 6'd47, 3'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 10'd313, 6'd47, 3'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 10'd313, 6'd47, 3'd1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 10'd330, 6'd30, 3'd3, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 10'd330, 6'd30, 3'd4, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 10'd330, 6'd30, 3'd3, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 10'd330, 6'd30, 3'd4, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'd313, 6'd47, 3'd0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            frame_tick = vecs[i].ft; anim_tick = vecs[i].at;
            jump = vecs[i].jp; duck = vecs[i].dk; game_state = vecs[i].gs;
            step();
            frame_tick = 1'b0; anim_tick = 1'b0;
            chk($sformatf("vec%0d_y", i), dino_y, vecs[i].y);
            chk($sformatf("vec%0d_h", i), dino_h, vecs[i].h);
            chk($sformatf("vec%0d_pose", i), pose, vecs[i].ps);
            chk($sformatf("vec%0d_air", i), airborne, vecs[i].air);
            chk($sformatf("vec%0d_start", i), start_req, vecs[i].sr);
        end

        // Full ground jump with a dropped mid-air edge and jump held through landing
        do_reset();
        start_jump();
        for (int t = 1; t <= 31; t++) begin
            if (t == 5) jump = 1'b0;
            frame();
            if (t == 6) begin
                step();
                jump = 1'b1;
                step();
            end
            exp_h = -1;
            case (t)
                1:  exp_h = 15;
                2:  exp_h = 29;
                15: exp_h = 120;
                16: exp_h = 120;
                17: exp_h = 119;
                30: exp_h = 15;
                default: exp_h = -1;
            endcase
            if (exp_h >= 0) chk($sformatf("jump_t%0d_y", t), dino_y, 313 - exp_h);
            if (t < 31) chk($sformatf("jump_t%0d_pose", t), pose, 5);
        end
        chk("land_y", dino_y, 313);
        chk("land_pose", pose, 1);
        chk("land_air", airborne, 0);
        for (int k = 0; k < 3; k++) begin
            frame();
            chk($sformatf("norejump%0d_y", k), dino_y, 313);
        end

        // Duck-accelerated fall from the apex
        do_reset();
        start_jump();
        jump = 1'b0;
        for (int t = 1; t <= 15; t++) frame();
        duck = 1'b1;
        for (int t = 16; t <= 24; t++) begin
            frame();
            case (t)
                16: exp_h = 120;
                17: exp_h = 117;
                18: exp_h = 111;
                19: exp_h = 102;
                20: exp_h = 90;
                21: exp_h = 75;
                22: exp_h = 57;
                23: exp_h = 36;
                default: exp_h = 12;
            endcase
            chk($sformatf("duck_t%0d_y", t), dino_y, 313 - exp_h);
            chk($sformatf("duck_t%0d_pose", t), pose, 5);
        end
        frame();
        chk("duck_land_pose", pose, 3);
        chk("duck_land_y", dino_y, 330);
        chk("duck_land_air", airborne, 0);
        anim_tick = 1'b1;
        step();
        anim_tick = 1'b0;
        chk("duck_anim_pose", pose, 4);

        // Idle: jump edge requests start, no physics
        do_reset();
        jump = 1'b1;
        step();
        chk("idle_start_hi", start_req, 1);
        chk("idle_y", dino_y, 313);
        step();
        chk("idle_start_lo", start_req, 0);
        frame();
        chk("idle_frame_y", dino_y, 313);
        chk("idle_frame_air", airborne, 0);

        // Death mid-air freezes height
        do_reset();
        start_jump();
        for (int t = 1; t <= 5; t++) frame();
        chk("pre_dead_y", dino_y, 248);
        game_state = 2'b10;
        step();
        chk("dead_pose", pose, 6);
        chk("dead_y", dino_y, 248);
        for (int k = 0; k < 5; k++) begin
            frame();
            chk($sformatf("dead_frz%0d_y", k), dino_y, 248);
        end
        chk("dead_pose_end", pose, 6);

        // Reset in the middle of a jump
        do_reset();
        start_jump();
        for (int t = 1; t <= 9; t++) frame();
        chk("pre_rst_pose", pose, 5);
        rst = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("midrst_y", dino_y, 313);
        chk("midrst_pose", pose, 0);
        chk("midrst_air", airborne, 0);
        chk("midrst_h", dino_h, 47);
        rst = 1'b0;
        jump = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
